sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter in front of a single-request
// SDRAM wrapper. One transaction in flight at a time. Every output is
// registered. A per-grant watchdog forces completion if the downstream ack
// never arrives, and it sets a sticky error flag when it does so.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n_i,

  input  logic        p0_sel_i,
  input  logic        p0_wr_en_i,
  input  logic [3:0]  p0_wr_mask_i,
  input  logic [31:0] p0_address_i,
  input  logic [31:0] p0_data_i,
  output logic [31:0] p0_data_o,
  output logic        p0_ack_o,

  input  logic        p1_sel_i,
  input  logic        p1_wr_en_i,
  input  logic [3:0]  p1_wr_mask_i,
  input  logic [31:0] p1_address_i,
  input  logic [31:0] p1_data_i,
  output logic [31:0] p1_data_o,
  output logic        p1_ack_o,

  output logic        mem_sel_o,
  output logic        mem_wr_en_o,
  output logic [3:0]  mem_wr_mask_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,

  output logic        timeout_err_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state_q,       state_d;
  logic          last_grant_q,  last_grant_d;  // 1 = port 1 was granted last
  logic          grant_q,       grant_d;       // port owning the current transaction
  logic [CW-1:0] cnt_q,         cnt_d;
  logic          mem_sel_q,     mem_sel_d;
  logic          mem_wr_en_q,   mem_wr_en_d;
  logic [3:0]    mem_wr_mask_q, mem_wr_mask_d;
  logic [31:0]   mem_address_q, mem_address_d;
  logic [31:0]   mem_data_q,    mem_data_d;
  logic          p0_ack_q,      p0_ack_d;
  logic          p1_ack_q,      p1_ack_d;
  logic [31:0]   p0_data_q,     p0_data_d;
  logic [31:0]   p1_data_q,     p1_data_d;
  logic          timeout_err_q, timeout_err_d;
  logic          win;

  // Next-state logic: arbitration, request latching, ack/timeout completion
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    mem_sel_d     = mem_sel_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_wr_mask_d = mem_wr_mask_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    p0_ack_d      = 1'b0;
    p1_ack_d      = 1'b0;
    p0_data_d     = p0_data_q;
    p1_data_d     = p1_data_q;
    timeout_err_d = timeout_err_q;
    win           = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0_sel_i || p1_sel_i) begin
          // On a tie the port that did not win last time takes the grant
          win           = (p0_sel_i && p1_sel_i) ? ~last_grant_q : p1_sel_i;
          grant_d       = win;
          last_grant_d  = win;
          cnt_d         = '0;
          mem_sel_d     = 1'b1;
          mem_wr_en_d   = win ? p1_wr_en_i   : p0_wr_en_i;
          mem_wr_mask_d = win ? p1_wr_mask_i : p0_wr_mask_i;
          mem_address_d = win ? p1_address_i : p0_address_i;
          mem_data_d    = win ? p1_data_i    : p0_data_i;
          state_d       = ISSUE;
        end
      end

      // Downstream ack seen here still belongs to the previous transaction
      ISSUE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = WAIT;
      end

      WAIT: begin
        if (mem_ack_i) begin
          if (grant_q) p1_data_d = mem_data_i;
          else         p0_data_d = mem_data_i;
          p0_ack_d  = ~grant_q;
          p1_ack_d  = grant_q;
          mem_sel_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          if (!mem_wr_en_q) begin
            if (grant_q) p1_data_d = ERR_DATA;
            else         p0_data_d = ERR_DATA;
          end
          p0_ack_d      = ~grant_q;
          p1_ack_d      = grant_q;
          mem_sel_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      cnt_q         <= '0;
      mem_sel_q     <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_mask_q <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_data_q     <= '0;
      p1_data_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      mem_sel_q     <= mem_sel_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_mask_q <= mem_wr_mask_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
      p0_data_q     <= p0_data_d;
      p1_data_q     <= p1_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_sel_o     = mem_sel_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_wr_mask_o = mem_wr_mask_q;
  assign mem_address_o = mem_address_q;
  assign mem_data_o    = mem_data_q;
  assign p0_ack_o      = p0_ack_q;
  assign p1_ack_o      = p1_ack_q;
  assign p0_data_o     = p0_data_q;
  assign p1_data_o     = p1_data_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: transaction-level reference (round-robin winner,
// expected read data per port, sticky error flag) driven by directed and
// randomized request rounds.
module tb_sdram_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        p0_sel_i, p0_wr_en_i, p1_sel_i, p1_wr_en_i;
  logic [3:0]  p0_wr_mask_i, p1_wr_mask_i;
  logic [31:0] p0_address_i, p0_data_i, p1_address_i, p1_data_i;
  logic [31:0] p0_data_o, p1_data_o;
  logic        p0_ack_o, p1_ack_o;
  logic        mem_sel_o, mem_wr_en_o;
  logic [3:0]  mem_wr_mask_o;
  logic [31:0] mem_address_o, mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic        timeout_err_o;

  sdram_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .p0_sel_i(p0_sel_i), .p0_wr_en_i(p0_wr_en_i), .p0_wr_mask_i(p0_wr_mask_i),
    .p0_address_i(p0_address_i), .p0_data_i(p0_data_i),
    .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_sel_i(p1_sel_i), .p1_wr_en_i(p1_wr_en_i), .p1_wr_mask_i(p1_wr_mask_i),
    .p1_address_i(p1_address_i), .p1_data_i(p1_data_i),
    .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_sel_o(mem_sel_o), .mem_wr_en_o(mem_wr_en_o), .mem_wr_mask_o(mem_wr_mask_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state
  int          last_w;
  logic [31:0] exp_data [2];
  logic        exp_terr;
  logic        req_we   [2];
  logic [3:0]  req_mask [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdat [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic s, input logic we, input logic [3:0] m,
                            input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_sel_i = s; p0_wr_en_i = we; p0_wr_mask_i = m; p0_address_i = a; p0_data_i = d;
    end else begin
      p1_sel_i = s; p1_wr_en_i = we; p1_wr_mask_i = m; p1_address_i = a; p1_data_i = d;
    end
  endtask

  task automatic check_latched(input string tag, input int w);
    check({tag, "_sel"},  mem_sel_o,     1'b1);
    check({tag, "_we"},   mem_wr_en_o,   req_we[w]);
    check({tag, "_mask"}, mem_wr_mask_o, req_mask[w]);
    check({tag, "_addr"}, mem_address_o, req_addr[w]);
    check({tag, "_wdat"}, mem_data_o,    req_wdat[w]);
    check({tag, "_ack0"}, p0_ack_o,      1'b0);
    check({tag, "_ack1"}, p1_ack_o,      1'b0);
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_d0"},   p0_data_o,     exp_data[0]);
    check({tag, "_d1"},   p1_data_o,     exp_data[1]);
    check({tag, "_terr"}, timeout_err_o, exp_terr);
  endtask

  // One complete request round starting from IDLE.
  // lat < 0 means the memory never answers.
  task automatic run_round(input bit s0, input bit s1, input int lat,
                           input bit stale, input bit drop_win, input logic [31:0] rd);
    int w;
    int n;
    bit seen;
    drive_port(0, s0, req_we[0], req_mask[0], req_addr[0], req_wdat[0]);
    drive_port(1, s1, req_we[1], req_mask[1], req_addr[1], req_wdat[1]);
    mem_ack_i  = stale;
    mem_data_i = $urandom;
    w = (s0 && s1) ? ((last_w == 0) ? 1 : 0) : (s1 ? 1 : 0);
    last_w = w;
    tick();
    check_latched("grant", w);

    // ISSUE cycle: stale ack, loser withdraws, winner changes its inputs
    mem_ack_i  = stale;
    mem_data_i = $urandom;
    drive_port(1 - w, 1'b0, $urandom, $urandom, $urandom, $urandom);
    drive_port(w, 1'b1, $urandom, $urandom, $urandom, $urandom);
    tick();
    check_latched("issue", w);

    mem_ack_i = 1'b0;
    if (drop_win) drive_port(w, 1'b0, $urandom, $urandom, $urandom, $urandom);
    if (lat >= 0) begin
      for (int i = 0; i < lat; i++) begin
        tick();
        check_latched("wait", w);
      end
      mem_ack_i  = 1'b1;
      mem_data_i = rd;
      tick();
      exp_data[w] = rd;
    end else begin
      n = 0;
      seen = 0;
      while (!seen && n < int'(4 * TO + 8)) begin
        tick();
        n++;
        if (p0_ack_o || p1_ack_o) seen = 1;
      end
      check("to_seen", seen, 1'b1);
      check("to_latency_ok", (n >= int'(TO) && n <= int'(TO) + 1), 1'b1);
      if (!req_we[w]) exp_data[w] = ERR;
      exp_terr = 1'b1;
    end

    // RESP cycle
    mem_ack_i  = stale;
    mem_data_i = $urandom;
    check("resp_ack0",   p0_ack_o,  (w == 0));
    check("resp_ack1",   p1_ack_o,  (w == 1));
    check("resp_memsel", mem_sel_o, 1'b0);
    check_hold("resp");
    drive_port(w, 1'b0, $urandom, $urandom, $urandom, $urandom);
    tick();

    // IDLE cycle, nobody requesting
    mem_ack_i = 1'b0;
    check("idle_ack0",   p0_ack_o,  1'b0);
    check("idle_ack1",   p1_ack_o,  1'b0);
    check("idle_memsel", mem_sel_o, 1'b0);
    check_hold("idle");
  endtask

  task automatic rand_req(input int p);
    req_we[p]   = $urandom_range(0, 1);
    req_mask[p] = $urandom;
    req_addr[p] = $urandom;
    req_addr[p][31] = (p == 1);
    req_wdat[p] = $urandom;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_memsel"}, mem_sel_o,     1'b0);
    check({tag, "_we"},     mem_wr_en_o,   1'b0);
    check({tag, "_mask"},   mem_wr_mask_o, 4'h0);
    check({tag, "_addr"},   mem_address_o, 32'h0);
    check({tag, "_wdat"},   mem_data_o,    32'h0);
    check({tag, "_ack0"},   p0_ack_o,      1'b0);
    check({tag, "_ack1"},   p1_ack_o,      1'b0);
    check({tag, "_d0"},     p0_data_o,     32'h0);
    check({tag, "_d1"},     p1_data_o,     32'h0);
    check({tag, "_terr"},   timeout_err_o, 1'b0);
  endtask

  initial begin
    int lat;
    bit s0, s1;
    reset_n_i = 1'b0;
    drive_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_ack_i = 1'b0;
    mem_data_i = 32'h0;
    last_w = 1;
    exp_data[0] = '0;
    exp_data[1] = '0;
    exp_terr = 1'b0;
    for (int p = 0; p < 2; p++) rand_req(p);
    tick();
    tick();
    check_reset_state("reset");
    reset_n_i = 1'b1;
    tick();

    // Both ports contend from reset: p0, p1, p0
    for (int r = 0; r < 3; r++) begin
      rand_req(0);
      rand_req(1);
      run_round(1, 1, r, 0, 0, $urandom);
    end

    // p0 read at 0x100 with ack stale in ISSUE and lingering after
    req_we[0] = 1'b0; req_mask[0] = 4'hF; req_addr[0] = 32'h100; req_wdat[0] = 32'h0;
    run_round(1, 0, 0, 1, 0, 32'h12345678);

    // p1 write that changes its inputs after the grant
    req_we[1] = 1'b1; req_mask[1] = 4'b0011; req_addr[1] = 32'h2000; req_wdat[1] = 32'hA5A5A5A5;
    run_round(0, 1, 2, 0, 0, 32'h0BADF00D);

    // p0 read that never gets a memory ack
    req_we[0] = 1'b0; req_mask[0] = 4'h0; req_addr[0] = 32'h40; req_wdat[0] = 32'h0;
    run_round(1, 0, -1, 0, 0, 32'h0);

    // Randomized rounds
    for (int r = 0; r < 60; r++) begin
      rand_req(0);
      rand_req(1);
      s0 = $urandom_range(0, 1);
      s1 = $urandom_range(0, 1);
      if (!s0 && !s1) s0 = 1'b1;
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      run_round(s0, s1, lat, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
    end

    // Reset pulse during WAIT aborts the transaction
    rand_req(0);
    req_we[0] = 1'b0;
    drive_port(0, 1'b1, req_we[0], req_mask[0], req_addr[0], req_wdat[0]);
    tick();
    tick();
    check("prerst_memsel", mem_sel_o, 1'b1);
    reset_n_i = 1'b0;
    #1;
    check_reset_state("midrst");
    exp_data[0] = '0;
    exp_data[1] = '0;
    exp_terr = 1'b0;
    last_w = 1;
    drive_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_ack0",   p0_ack_o,  1'b0);
      check("postrst_ack1",   p1_ack_o,  1'b0);
      check("postrst_memsel", mem_sel_o, 1'b0);
    end
    rand_req(0);
    rand_req(1);
    run_round(1, 1, 1, 0, 0, $urandom);
    rand_req(1);
    run_round(0, 1, 0, 1, 1, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
